matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The block SHALL take its parameters MAX_DIM, DATA_WIDTH, BUS_WIDTH, SP_NTARGETS and SP_AW from matmul_pkg: MAX_DIM default 4 (max matrix dimension); SP_NTARGETS default 4 (scratchpad banks); SP_AW = clog2(MAX_DIM*MAX_DIM) (element address width).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have these ports:
- clk_i, input, 1 bit: clock, rising edge.
- rst_ni, input, 1 bit: asynchronous reset, active low.
- start_i, input, 1 bit: control-register start bit (level).
- mode_i, input, 1 bit: 1 = accumulate onto a scratchpad bias.
- write_target_i, input, 2 bits: scratchpad bank for results.
- read_target_i, input, 2 bits: scratchpad bank for bias (used when mode=1).
- dim_n_i, dim_k_i, dim_m_i, inputs, clog2(MAX_DIM) bits each: dimensions encoded as value-1.
- busy_o, output, 1 bit: operation in progress.
- done_o, output, 1 bit: one-cycle completion pulse.
- clear_start_o, output, 1 bit: one-cycle pulse that clears control bit0.
- pe_clr_o, output, 1 bit: clear PE accumulators.
- feed_en_o, output, 1 bit: operand feeders and PE array advance.
- feed_step_o, output, clog2(3*MAX_DIM) bits: current skew step.
- sp_rd_en_o, output, 1 bit: scratchpad bias read request.
- sp_rd_sel_o, output, 2 bits: bank for the bias read.
- sp_rd_addr_o, output, SP_AW bits: element address for the bias read.
- add_bias_o, output, 1 bit: datapath adds the read data to the PE result.
- sp_wr_en_o, output, 1 bit: scratchpad result write.
- sp_wr_sel_o, output, 2 bits: bank for the result write.
- sp_wr_addr_o, output, SP_AW bits: element address for the result write.

Function
REQ-004 FSM states SHALL be IDLE, CLEAR, COMPUTE, WRBACK, DONE; reset state IDLE.
REQ-005 In IDLE, busy_o=0 and start_i=1 SHALL register mode, targets and dims, then go to CLEAR next cycle; config inputs SHALL be ignored in every other state.
REQ-006 CLEAR SHALL last 1 cycle with pe_clr_o=1, clear_start_o=1, busy_o=1, then go to COMPUTE.
REQ-007 COMPUTE SHALL assert feed_en_o, with feed_step_o counting from 0 to n+k+m (registered codes), i.e. K+N+M-2 cycles for real dims; after the last step the FSM SHALL go to WRBACK.
REQ-008 WRBACK SHALL scan the elements row-major, i=0..n, j=0..m, one element per cycle, with address = i*MAX_DIM+j; elements outside n x m SHALL never be addressed.
REQ-009 When mode=0, each WRBACK cycle SHALL assert sp_wr_en_o with the current address, and sp_rd_en_o and add_bias_o SHALL stay 0.
REQ-010 When mode=1, sp_rd_en_o SHALL be issued for element e in cycle t, and sp_wr_en_o plus add_bias_o SHALL follow for element e in cycle t+1 (1-cycle read latency); WRBACK therefore lasts (n+1)(m+1)+1 cycles.
REQ-011 read_target equal to write_target SHALL be legal, because every read of an element precedes its write.
REQ-012 DONE SHALL last 1 cycle with done_o=1 and busy_o=1, then go to IDLE; busy_o SHALL fall on the cycle after done_o.
REQ-013 busy_o SHALL be 1 in all states except IDLE.
REQ-014 start_i still high on the IDLE return cycle SHALL begin a new operation, since clearing the start bit is the register file's responsibility.
REQ-015 The block SHALL set all outputs from registers; it SHALL have no combinational path from input to output.

Reset
REQ-016 rst_ni=0 SHALL force the FSM to IDLE asynchronously, clear all counters and config registers, and drive every output to 0, in any state.
REQ-017 A reset during COMPUTE or WRBACK SHALL abandon the operation with no done_o, and no further sp_wr_en_o SHALL occur after reset deasserts.

Structure
REQ-018 matmul_pkg SHALL hold MAX_DIM, DATA_WIDTH, BUS_WIDTH, SP_NTARGETS, SP_AW and the sequencer state enum type.
REQ-019 The row/column scan SHALL be a sub-module named matmul_index_counter (clear, enable, limits n/m, outputs i, j, last).

Verification
REQ-020 Test n=k=m=3, mode=0, wt=2: start -> CLEAR 1 cycle, COMPUTE 10 cycles (steps 0..9), 16 writes to bank 2 at addresses 0..15, done_o 28 cycles after start is sampled.
REQ-021 Test n=1, k=2, m=0, mode=1, rt=1, wt=3: 2 reads from bank 1 at addresses 0 and 4, each followed next cycle by a write to bank 3 at the same address with add_bias_o=1; WRBACK lasts 3 cycles.
REQ-022 Test n=k=m=0: COMPUTE 1 cycle, exactly 1 write at address 0, then done_o; busy_o is high for 4 cycles.
REQ-023 Toggle start_i during COMPUTE with different dims: no effect, and the write count still matches the originally latched dims.
REQ-024 Pulse rst_ni low in the middle of WRBACK: all outputs are 0 immediately, no done_o, IDLE after release, and the next start runs normally.
REQ-025 Hold start_i high across done_o: a second operation begins the cycle after IDLE is entered, with clear_start_o pulsing again.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared sizing parameters, sequencer state type and element addressing for the
// matrix-multiply sequencer slice.
package matmul_pkg;

    localparam int MAX_DIM     = 4;
    localparam int DATA_WIDTH  = 16;
    localparam int BUS_WIDTH   = 64;
    localparam int SP_NTARGETS = 4;
    localparam int SP_AW       = $clog2(MAX_DIM * MAX_DIM);
    localparam int DIM_W       = $clog2(MAX_DIM);
    localparam int STEP_W      = $clog2(3 * MAX_DIM);
    localparam int TGT_W       = $clog2(SP_NTARGETS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COMPUTE,
        ST_WRBACK,
        ST_DONE
    } seq_state_e;

    // Scratchpad rows are MAX_DIM elements wide regardless of the active n x m.
    function automatic logic [SP_AW-1:0] elem_addr(input logic [DIM_W-1:0] i,
                                                   input logic [DIM_W-1:0] j);
        return SP_AW'(int'(i) * MAX_DIM + int'(j));
    endfunction

endpackage

// File: rtl/matmul_index_counter.sv
// Row-major (i, j) scan over an (n+1) x (m+1) result tile; limits are value-1 codes.
module matmul_index_counter
    import matmul_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIM_W-1:0] n_i,
    input  logic [DIM_W-1:0] m_i,
    output logic [DIM_W-1:0] i_o,
    output logic [DIM_W-1:0] j_o,
    output logic             last_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_o <= '0;
            j_o <= '0;
        end else if (clr_i) begin
            i_o <= '0;
            j_o <= '0;
        end else if (en_i) begin
            if (j_o == m_i) begin
                j_o <= '0;
                i_o <= (i_o == n_i) ? '0 : i_o + DIM_W'(1);
            end else begin
                j_o <= j_o + DIM_W'(1);
            end
        end
    end

    assign last_o = (i_o == n_i) && (j_o == m_i);

endmodule

// File: rtl/matmul_sequencer.sv
// Control sequencer for the systolic matmul: clears the PEs, drives the skewed feed,
// then writes results back to the scratchpad, optionally adding a bias read first.
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [TGT_W-1:0]  write_target_i,
    input  logic [TGT_W-1:0]  read_target_i,
    input  logic [DIM_W-1:0]  dim_n_i,
    input  logic [DIM_W-1:0]  dim_k_i,
    input  logic [DIM_W-1:0]  dim_m_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              clear_start_o,
    output logic              pe_clr_o,
    output logic              feed_en_o,
    output logic [STEP_W-1:0] feed_step_o,
    output logic              sp_rd_en_o,
    output logic [TGT_W-1:0]  sp_rd_sel_o,
    output logic [SP_AW-1:0]  sp_rd_addr_o,
    output logic              add_bias_o,
    output logic              sp_wr_en_o,
    output logic [TGT_W-1:0]  sp_wr_sel_o,
    output logic [SP_AW-1:0]  sp_wr_addr_o
);

    seq_state_e        state_q;
    logic              mode_q;
    logic [TGT_W-1:0]  wt_q;
    logic [TGT_W-1:0]  rt_q;
    logic [DIM_W-1:0]  n_q;
    logic [DIM_W-1:0]  k_q;
    logic [DIM_W-1:0]  m_q;
    logic              scan_end_q;

    logic [DIM_W-1:0]  idx_i;
    logic [DIM_W-1:0]  idx_j;
    logic              idx_last;
    logic              idx_clr;
    logic              idx_en;
    logic [STEP_W-1:0] step_max;
    logic              compute_last;
    logic              bias_pending;

    assign step_max     = STEP_W'(n_q) + STEP_W'(k_q) + STEP_W'(m_q);
    assign compute_last = (state_q == ST_COMPUTE) && (feed_step_o == step_max);
    // The first element is issued on the COMPUTE->WRBACK edge so WRBACK has no bubble.
    assign idx_en       = compute_last || ((state_q == ST_WRBACK) && !scan_end_q);
    assign idx_clr      = (state_q == ST_IDLE);
    assign bias_pending = mode_q && sp_rd_en_o;

    matmul_index_counter u_index_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (idx_clr),
        .en_i   (idx_en),
        .n_i    (n_q),
        .m_i    (m_q),
        .i_o    (idx_i),
        .j_o    (idx_j),
        .last_o (idx_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            mode_q        <= 1'b0;
            wt_q          <= '0;
            rt_q          <= '0;
            n_q           <= '0;
            k_q           <= '0;
            m_q           <= '0;
            scan_end_q    <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            clear_start_o <= 1'b0;
            pe_clr_o      <= 1'b0;
            feed_en_o     <= 1'b0;
            feed_step_o   <= '0;
            sp_rd_en_o    <= 1'b0;
            sp_rd_sel_o   <= '0;
            sp_rd_addr_o  <= '0;
            add_bias_o    <= 1'b0;
            sp_wr_en_o    <= 1'b0;
            sp_wr_sel_o   <= '0;
            sp_wr_addr_o  <= '0;
        end else begin
            pe_clr_o      <= 1'b0;
            clear_start_o <= 1'b0;
            done_o        <= 1'b0;
            sp_rd_en_o    <= 1'b0;
            sp_wr_en_o    <= 1'b0;
            add_bias_o    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q        <= mode_i;
                        wt_q          <= write_target_i;
                        rt_q          <= read_target_i;
                        n_q           <= dim_n_i;
                        k_q           <= dim_k_i;
                        m_q           <= dim_m_i;
                        state_q       <= ST_CLEAR;
                        busy_o        <= 1'b1;
                        pe_clr_o      <= 1'b1;
                        clear_start_o <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_q     <= ST_COMPUTE;
                    feed_en_o   <= 1'b1;
                    feed_step_o <= '0;
                    scan_end_q  <= 1'b0;
                end
                ST_COMPUTE: begin
                    if (compute_last) begin
                        state_q     <= ST_WRBACK;
                        feed_en_o   <= 1'b0;
                        feed_step_o <= '0;
                    end else begin
                        feed_step_o <= feed_step_o + STEP_W'(1);
                    end
                end
                ST_WRBACK: begin
                    // Bias read issued last cycle: its data is valid now, so write it back.
                    if (bias_pending) begin
                        sp_wr_en_o   <= 1'b1;
                        sp_wr_sel_o  <= wt_q;
                        sp_wr_addr_o <= sp_rd_addr_o;
                        add_bias_o   <= 1'b1;
                    end
                    if (scan_end_q && !bias_pending) begin
                        state_q <= ST_DONE;
                        done_o  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase

            if (idx_en) begin
                scan_end_q <= idx_last;
                if (mode_q) begin
                    sp_rd_en_o   <= 1'b1;
                    sp_rd_sel_o  <= rt_q;
                    sp_rd_addr_o <= elem_addr(idx_i, idx_j);
                end else begin
                    sp_wr_en_o   <= 1'b1;
                    sp_wr_sel_o  <= wt_q;
                    sp_wr_addr_o <= elem_addr(idx_i, idx_j);
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: cycle-accurate protocol checks per operation.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic              mode_i;
    logic [TGT_W-1:0]  write_target_i;
    logic [TGT_W-1:0]  read_target_i;
    logic [DIM_W-1:0]  dim_n_i;
    logic [DIM_W-1:0]  dim_k_i;
    logic [DIM_W-1:0]  dim_m_i;
    logic              busy_o;
    logic              done_o;
    logic              clear_start_o;
    logic              pe_clr_o;
    logic              feed_en_o;
    logic [STEP_W-1:0] feed_step_o;
    logic              sp_rd_en_o;
    logic [TGT_W-1:0]  sp_rd_sel_o;
    logic [SP_AW-1:0]  sp_rd_addr_o;
    logic              add_bias_o;
    logic              sp_wr_en_o;
    logic [TGT_W-1:0]  sp_wr_sel_o;
    logic [SP_AW-1:0]  sp_wr_addr_o;

    matmul_sequencer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .write_target_i (write_target_i),
        .read_target_i  (read_target_i),
        .dim_n_i        (dim_n_i),
        .dim_k_i        (dim_k_i),
        .dim_m_i        (dim_m_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .clear_start_o  (clear_start_o),
        .pe_clr_o       (pe_clr_o),
        .feed_en_o      (feed_en_o),
        .feed_step_o    (feed_step_o),
        .sp_rd_en_o     (sp_rd_en_o),
        .sp_rd_sel_o    (sp_rd_sel_o),
        .sp_rd_addr_o   (sp_rd_addr_o),
        .add_bias_o     (add_bias_o),
        .sp_wr_en_o     (sp_wr_en_o),
        .sp_wr_sel_o    (sp_wr_sel_o),
        .sp_wr_addr_o   (sp_wr_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    int wr_addr_q[$], wr_sel_q[$], wr_bias_q[$], wr_cyc_q[$];
    int rd_addr_q[$], rd_sel_q[$], rd_cyc_q[$];
    int clr_cnt, clr_cyc, pe_cnt, feed_cnt, feed_first, step_err, done_cyc, busy_cnt;
    int post_rst_wr, post_rst_done;
    logic [31:0] rst_snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_snapshot();
        return 32'({busy_o, done_o, clear_start_o, pe_clr_o, feed_en_o, feed_step_o,
                    sp_rd_en_o, sp_rd_sel_o, sp_rd_addr_o, add_bias_o,
                    sp_wr_en_o, sp_wr_sel_o, sp_wr_addr_o});
    endfunction

    task automatic go(input bit md, input int wt, input int rt,
                      input int n, input int k, input int m);
        mode_i         = md;
        write_target_i = wt[TGT_W-1:0];
        read_target_i  = rt[TGT_W-1:0];
        dim_n_i        = n[DIM_W-1:0];
        dim_k_i        = k[DIM_W-1:0];
        dim_m_i        = m[DIM_W-1:0];
        start_i        = 1'b1;
    endtask

    // Cycle 1 is the first cycle after the edge that samples start_i.
    task automatic observe(input int max_cyc, input bit hold, input bit toggle,
                           input int rst_at_wr);
        bit in_tail = 1'b0;
        int tail    = 0;
        wr_addr_q.delete(); wr_sel_q.delete(); wr_bias_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_sel_q.delete(); rd_cyc_q.delete();
        clr_cnt = 0; clr_cyc = 0; pe_cnt = 0; feed_cnt = 0; feed_first = 0; step_err = 0;
        done_cyc = -1; busy_cnt = 0; post_rst_wr = 0; post_rst_done = 0; rst_snap = '1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk_i);
            if (in_tail) begin
                if (sp_wr_en_o) post_rst_wr++;
                if (done_o) post_rst_done++;
                tail++;
                if (tail == 8) break;
                continue;
            end
            if (busy_o) busy_cnt++;
            if (pe_clr_o) pe_cnt++;
            if (clear_start_o) begin clr_cnt++; clr_cyc = c; end
            if (feed_en_o) begin
                if (feed_cnt == 0) feed_first = c;
                if (int'(feed_step_o) != feed_cnt) step_err++;
                feed_cnt++;
            end
            if (sp_wr_en_o) begin
                wr_addr_q.push_back(int'(sp_wr_addr_o));
                wr_sel_q.push_back(int'(sp_wr_sel_o));
                wr_bias_q.push_back(int'(add_bias_o));
                wr_cyc_q.push_back(c);
            end
            if (sp_rd_en_o) begin
                rd_addr_q.push_back(int'(sp_rd_addr_o));
                rd_sel_q.push_back(int'(sp_rd_sel_o));
                rd_cyc_q.push_back(c);
            end
            if (done_o) begin done_cyc = c; break; end
            if (c == 1 && !hold) start_i = 1'b0;
            if (toggle && c == 3) begin
                start_i = 1'b1; dim_n_i = '1; dim_k_i = '1; dim_m_i = '1; mode_i = ~mode_i;
            end
            if (toggle && c == 4) start_i = 1'b0;
            if (rst_at_wr > 0 && wr_addr_q.size() == rst_at_wr) begin
                rst_ni = 1'b0;
                #1;
                rst_snap = out_snapshot();
                @(negedge clk_i);
                rst_ni  = 1'b1;
                in_tail = 1'b1;
            end
        end
    endtask

    initial begin
        int exp_a[9];
        rst_ni = 1'b1; start_i = 1'b0; mode_i = 1'b0;
        write_target_i = '0; read_target_i = '0;
        dim_n_i = '0; dim_k_i = '0; dim_m_i = '0;
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("reset_outputs", out_snapshot(), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_busy", 32'(busy_o), 32'd0);

        // 3x3x3 (codes), mode 0, bank 2
        go(1'b0, 2, 0, 3, 3, 3);
        observe(60, 1'b0, 1'b0, 0);
        chk("t1_clr_cnt", clr_cnt, 1);
        chk("t1_clr_cyc", clr_cyc, 1);
        chk("t1_pe_clr_cnt", pe_cnt, 1);
        chk("t1_feed_cnt", feed_cnt, 10);
        chk("t1_feed_first", feed_first, 2);
        chk("t1_step_err", step_err, 0);
        chk("t1_wr_cnt", wr_addr_q.size(), 16);
        for (int e = 0; e < 16; e++) begin
            chk("t1_wr_addr", wr_addr_q[e], e);
            chk("t1_wr_sel", wr_sel_q[e], 2);
            chk("t1_wr_bias", wr_bias_q[e], 0);
        end
        chk("t1_first_wr_cyc", wr_cyc_q[0], 12);
        chk("t1_rd_cnt", rd_addr_q.size(), 0);
        chk("t1_done_cyc", done_cyc, 28);
        chk("t1_busy_cnt", busy_cnt, 28);
        @(negedge clk_i);
        chk("t1_busy_after_done", 32'(busy_o), 32'd0);
        chk("t1_done_one_cycle", 32'(done_o), 32'd0);

        // n=1 k=2 m=0, bias mode, read bank 1, write bank 3
        go(1'b1, 3, 1, 1, 2, 0);
        observe(60, 1'b0, 1'b0, 0);
        chk("t2_feed_cnt", feed_cnt, 4);
        chk("t2_rd_cnt", rd_addr_q.size(), 2);
        chk("t2_rd_addr0", rd_addr_q[0], 0);
        chk("t2_rd_addr1", rd_addr_q[1], 4);
        chk("t2_rd_sel0", rd_sel_q[0], 1);
        chk("t2_rd_sel1", rd_sel_q[1], 1);
        chk("t2_rd_cyc0", rd_cyc_q[0], 6);
        chk("t2_rd_cyc1", rd_cyc_q[1], 7);
        chk("t2_wr_cnt", wr_addr_q.size(), 2);
        chk("t2_wr_addr0", wr_addr_q[0], 0);
        chk("t2_wr_addr1", wr_addr_q[1], 4);
        chk("t2_wr_cyc0", wr_cyc_q[0], 7);
        chk("t2_wr_cyc1", wr_cyc_q[1], 8);
        chk("t2_wr_sel0", wr_sel_q[0], 3);
        chk("t2_wr_sel1", wr_sel_q[1], 3);
        chk("t2_bias0", wr_bias_q[0], 1);
        chk("t2_bias1", wr_bias_q[1], 1);
        chk("t2_wrback_len", wr_cyc_q[1] - rd_cyc_q[0] + 1, 3);
        chk("t2_done_cyc", done_cyc, 9);
        @(negedge clk_i);

        // 1x1x1
        go(1'b0, 0, 0, 0, 0, 0);
        observe(20, 1'b0, 1'b0, 0);
        chk("t3_feed_cnt", feed_cnt, 1);
        chk("t3_wr_cnt", wr_addr_q.size(), 1);
        chk("t3_wr_addr", wr_addr_q[0], 0);
        chk("t3_done_cyc", done_cyc, 4);
        chk("t3_busy_cnt", busy_cnt, 4);
        @(negedge clk_i);
        chk("t3_busy_after", 32'(busy_o), 32'd0);

        // start/config toggled mid-COMPUTE must not disturb latched n=2 k=1 m=2
        go(1'b0, 1, 0, 2, 1, 2);
        observe(60, 1'b0, 1'b1, 0);
        exp_a = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        chk("t4_feed_cnt", feed_cnt, 6);
        chk("t4_wr_cnt", wr_addr_q.size(), 9);
        for (int e = 0; e < 9; e++) chk("t4_wr_addr", wr_addr_q[e], exp_a[e]);
        chk("t4_rd_cnt", rd_addr_q.size(), 0);
        chk("t4_done_cyc", done_cyc, 17);
        @(negedge clk_i);

        // reset pulse after the 5th write-back
        go(1'b0, 2, 0, 3, 3, 3);
        observe(100, 1'b0, 1'b0, 5);
        chk("t5_rst_outputs_zero", rst_snap, 32'd0);
        chk("t5_no_done", done_cyc, -1);
        chk("t5_post_rst_wr", post_rst_wr, 0);
        chk("t5_post_rst_done", post_rst_done, 0);
        chk("t5_idle_after", 32'(busy_o), 32'd0);
        go(1'b0, 1, 0, 1, 0, 1);
        observe(40, 1'b0, 1'b0, 0);
        chk("t5b_wr_cnt", wr_addr_q.size(), 4);
        chk("t5b_wr_addr0", wr_addr_q[0], 0);
        chk("t5b_wr_addr1", wr_addr_q[1], 1);
        chk("t5b_wr_addr2", wr_addr_q[2], 4);
        chk("t5b_wr_addr3", wr_addr_q[3], 5);
        chk("t5b_wr_sel", wr_sel_q[0], 1);
        chk("t5b_done_cyc", done_cyc, 9);
        @(negedge clk_i);

        // start held high across done: back-to-back operations
        go(1'b0, 0, 0, 0, 0, 0);
        observe(20, 1'b1, 1'b0, 0);
        chk("t6_done_cyc", done_cyc, 4);
        @(negedge clk_i);
        chk("t6_idle_busy", 32'(busy_o), 32'd0);
        chk("t6_idle_clr", 32'(clear_start_o), 32'd0);
        @(negedge clk_i);
        chk("t6_restart_clr", 32'(clear_start_o), 32'd1);
        chk("t6_restart_busy", 32'(busy_o), 32'd1);
        start_i = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk_i);
                if (done_o) seen = 1'b1;
            end
            chk("t6_second_done", 32'(seen), 32'd1);
        end
        @(negedge clk_i);
        chk("t6_final_idle", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
